wb_sci_arbiter: RTL
===================

WB_SCI_ARBITER -- requirements
Module: wb_sci_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, is the number of Wishbone requesters sharing the SCI bridge (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, is the Wishbone address width (>=16).
REQ-003 Parameter DATA_WIDTH, default 32, is the Wishbone data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, is the outstanding-request cycle limit before abort.
REQ-005 The port list SHALL be, in order:
- CLK  in  1  single clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- M_CYC, M_STB, M_WE  in  NUM_MASTERS each  per-master bus cycle / strobe / write-not-read.
- M_ADDR  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i.
- M_WDATA  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- M_SEL  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte select.
- M_STALL, M_ACK, M_ERR  out  NUM_MASTERS each  per-master stall / ack / error.
- M_RDATA  out  DATA_WIDTH  read data, shared by all masters.
- S_CYC, S_STB, S_WE  out  1 each  to the bridge.
- S_ADDR  out  ADDR_WIDTH; S_WDATA  out  DATA_WIDTH; S_SEL  out  DATA_WIDTH/8.
- S_STALL, S_ACK, S_ERR  in  1 each  from the bridge.
- S_RDATA  in  DATA_WIDTH  from the bridge.
- GRANT  out  NUM_MASTERS  one-hot current owner; all-zero when none.

Function
REQ-006 The FSM SHALL have states IDLE, OWN and ABORT.
REQ-007 In IDLE, with any M_CYC high, the block SHALL select the first requester at or after index (last_owner+1) mod NUM_MASTERS, set GRANT one-hot and enter OWN on the next edge. Arbitration latency is 1 cycle.
REQ-008 In IDLE, S_CYC and S_STB SHALL be 0, all M_STALL SHALL be 1 and all M_ACK and M_ERR SHALL be 0.
REQ-009 In OWN, the owner's CYC, STB, WE, ADDR, WDATA and SEL SHALL drive the S_* outputs combinationally. S_STALL, S_ACK and S_ERR SHALL route only to the owner's M_STALL, M_ACK and M_ERR. M_RDATA SHALL equal S_RDATA.
REQ-010 Non-owners SHALL see M_STALL=1, M_ACK=0 and M_ERR=0 in every state.
REQ-011 The outstanding flag SHALL set on S_STB && !S_STALL and clear on S_ACK || S_ERR. It clears on the same edge if both occur.
REQ-012 When the owner drops M_CYC in OWN, the block SHALL go to IDLE and record last_owner. Any outstanding request is abandoned, and a later S_ACK/S_ERR in IDLE SHALL be discarded.
REQ-013 The owner SHALL keep the grant for back-to-back transfers while its M_CYC stays high. There is no preemption.
REQ-014 ABORT behaviour is defined in REQ-019/020 and is reachable only when WB_ARB_TIMEOUT_EN is defined.
REQ-015 GRANT SHALL be registered and change only on FSM transitions.

Reset
REQ-016 While RST is high at a clock edge, the state SHALL become IDLE, GRANT=0, last_owner=NUM_MASTERS-1 (so master 0 wins first), the outstanding flag=0 and the timeout counter=0.
REQ-017 Reset asserted mid-transfer SHALL abandon the transfer. Outputs SHALL take IDLE values from the cycle after the reset edge.

Configuration
REQ-018 The macro WB_ARB_TIMEOUT_EN SHALL select the outstanding-request timeout.
REQ-019 With WB_ARB_TIMEOUT_EN defined, the counter SHALL increment each OWN cycle while outstanding && !S_ACK && !S_ERR, and clear otherwise. When it reaches TIMEOUT_CYCLES-1, the block SHALL pulse M_ERR[owner] for 1 cycle, clear the outstanding flag and enter ABORT.
REQ-020 In ABORT, S_CYC and S_STB SHALL be 0, the owner SHALL see STALL=1, and the FSM SHALL return to IDLE when the owner drops M_CYC.
REQ-021 Without WB_ARB_TIMEOUT_EN, no counter or ABORT logic SHALL exist, and an unanswered request SHALL hold OWN indefinitely.

Verification
REQ-022 Reset, then M_CYC=M_STB=2'b11 with a write to 0x0105 -> GRANT=2'b01 one cycle later, S_ADDR=0x0105 and M_ACK[0] on the bridge ack; M_STALL[1]=1 throughout.
REQ-023 Master 0 releases while master 1 is still requesting -> 1 IDLE cycle, then GRANT=2'b10. Master 1 releases while master 0 is requesting -> GRANT=2'b01 (round-robin).
REQ-024 Master 1 issues a read to 0x8203 and the bridge returns S_RDATA=0xDEADBEEF with S_ACK -> M_ACK=2'b10 and M_RDATA=0xDEADBEEF on the same cycle.
REQ-025 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, read with S_ACK never asserted -> M_ERR[0] pulses at the 16th outstanding cycle, S_CYC drops, and IDLE is entered after M_CYC[0] falls.
REQ-026 RST asserted during an outstanding write -> next cycle GRANT=0, S_CYC=0; a stray S_ACK one cycle later produces no M_ACK.
REQ-027 Owner drops M_CYC with a request outstanding, then S_ACK arrives in IDLE -> no M_ACK to any master, and the next grant proceeds normally.

Source files
------------

// File: rtl/wb_sci_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS Wishbone masters share one SCI bridge port.
// Defining WB_ARB_TIMEOUT_EN adds an outstanding-request timeout that aborts a stuck owner.
module wb_sci_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_MASTERS-1:0]              M_CYC,
  input  logic [NUM_MASTERS-1:0]              M_STB,
  input  logic [NUM_MASTERS-1:0]              M_WE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   M_ADDR,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   M_WDATA,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] M_SEL,
  output logic [NUM_MASTERS-1:0]              M_STALL,
  output logic [NUM_MASTERS-1:0]              M_ACK,
  output logic [NUM_MASTERS-1:0]              M_ERR,
  output logic [DATA_WIDTH-1:0]               M_RDATA,
  output logic                                S_CYC,
  output logic                                S_STB,
  output logic                                S_WE,
  output logic [ADDR_WIDTH-1:0]               S_ADDR,
  output logic [DATA_WIDTH-1:0]               S_WDATA,
  output logic [DATA_WIDTH/8-1:0]             S_SEL,
  input  logic                                S_STALL,
  input  logic                                S_ACK,
  input  logic                                S_ERR,
  input  logic [DATA_WIDTH-1:0]               S_RDATA,
  output logic [NUM_MASTERS-1:0]              GRANT
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SelW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   outstanding_q, outstanding_d;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] count_q, count_d;
  logic            timeout_hit;
`endif

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
  logic [SelW-1:0]       sel_arr   [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
    assign addr_arr[g]  = M_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = M_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[g]   = M_SEL[g*SelW +: SelW];
  end

  // Round-robin search starts just after the previous owner.
  logic [IdxW-1:0] pick, cand;
  logic            pick_valid;

  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_MASTERS);
      if (!pick_valid && M_CYC[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    grant_d       = grant_q;
    outstanding_d = 1'b0;
    S_CYC         = 1'b0;
    S_STB         = 1'b0;
    S_WE          = M_WE[owner_q];
    S_ADDR        = addr_arr[owner_q];
    S_WDATA       = wdata_arr[owner_q];
    S_SEL         = sel_arr[owner_q];
    M_STALL       = '1;
    M_ACK         = '0;
    M_ERR         = '0;
    M_RDATA       = S_RDATA;
`ifdef WB_ARB_TIMEOUT_EN
    count_d       = '0;
    timeout_hit   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d       = StOwn;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      StOwn: begin
        S_CYC            = M_CYC[owner_q];
        S_STB            = M_STB[owner_q];
        M_STALL[owner_q] = S_STALL;
        M_ACK[owner_q]   = S_ACK;
        M_ERR[owner_q]   = S_ERR;
        // A response wins over a new acceptance on the same edge.
        if (S_ACK || S_ERR) begin
          outstanding_d = 1'b0;
        end else if (M_STB[owner_q] && !S_STALL) begin
          outstanding_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (outstanding_q && !S_ACK && !S_ERR) begin
          if (count_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
`endif
        if (!M_CYC[owner_q]) begin
          state_d       = StIdle;
          last_d        = owner_q;
          grant_d       = '0;
          outstanding_d = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
          count_d       = '0;
        end else if (timeout_hit) begin
          M_ERR[owner_q] = 1'b1;
          outstanding_d  = 1'b0;
          state_d        = StAbort;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      StAbort: begin
        if (!M_CYC[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      last_q        <= IdxW'(NUM_MASTERS - 1);
      grant_q       <= '0;
      outstanding_q <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      outstanding_q <= outstanding_d;
`ifdef WB_ARB_TIMEOUT_EN
      count_q       <= count_d;
`endif
    end
  end

  assign GRANT = grant_q;

endmodule
